// File: rtl/tmds_pkg.sv
// Shared TMDS receive constants: the four DVI control tokens, alignment FSM states
// and the bit-slip offset width.
package tmds_pkg;

  localparam int OFFSET_W = 4;
  localparam logic [OFFSET_W-1:0] OFFSET_LAST = 4'd9;

  localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  function automatic logic is_ctl_token(input logic [9:0] sym);
    return (sym == CTL_TOKEN_00) || (sym == CTL_TOKEN_01) ||
           (sym == CTL_TOKEN_10) || (sym == CTL_TOKEN_11);
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational 10b symbol decode: 8-bit pixel byte plus 2-bit control code.
// The control code is only meaningful when the symbol is one of the control tokens.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic [1:0] ctl
);

  logic [7:0] w;

  always_comb begin
    w       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = 8'h00;
    data[0] = w[0];
    // sym[8] selects the XOR or XNOR transition chain used by the encoder
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    end
    ctl = 2'b00;
    case (sym)
      CTL_TOKEN_01: ctl = 2'b01;
      CTL_TOKEN_10: ctl = 2'b10;
      CTL_TOKEN_11: ctl = 2'b11;
      default:      ctl = 2'b00;
    endcase
  end

endmodule

// File: rtl/tmds_decoder_align.sv
// Per-lane TMDS receiver: bit-slip word alignment on control tokens plus 10b decode.
// Optional macro TMDS_DECODER_LOSS_CNT_EN adds out_loss_cnt (saturating lock-loss count).
module tmds_decoder_align
  import tmds_pkg::*;
#(
  parameter int C_lock_tokens    = 8,
  parameter int C_search_timeout = 4096,
  parameter int C_loss_timeout   = 4096
) (
  input  logic                clk_pixel,
  input  logic                rst_n,
  input  logic [9:0]          in_word,
  output logic [7:0]          out_data,
  output logic [1:0]          out_c,
  output logic                out_de,
  output logic                out_locked,
  output logic [OFFSET_W-1:0] out_offset
`ifdef TMDS_DECODER_LOSS_CNT_EN
  ,
  output logic [15:0]         out_loss_cnt
`endif
);

  localparam int IDLE_MAX = (C_search_timeout > C_loss_timeout) ? C_search_timeout : C_loss_timeout;
  localparam int TOK_W    = $clog2(C_lock_tokens + 1);
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
  localparam logic [TOK_W-1:0]  TOK_LAST    = TOK_W'(C_lock_tokens - 1);
  localparam logic [IDLE_W-1:0] SEARCH_LAST = IDLE_W'(C_search_timeout - 1);
  localparam logic [IDLE_W-1:0] LOSS_LAST   = IDLE_W'(C_loss_timeout - 1);

  logic [9:0]          prev_word_q, prev_word_d;
  logic [9:0]          aligned_q, aligned_d;
  logic                is_ctl_q, is_ctl_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [1:0]          out_c_q, out_c_d;
  logic                out_de_q, out_de_d;
  align_state_e        state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [TOK_W-1:0]    tok_cnt_q, tok_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                settle_q, settle_d;
  logic                slip;
  logic [7:0]          dec_data;
  logic [1:0]          dec_ctl;

  // Stage 1: select the 10-bit window at the current offset, flag control tokens
  assign prev_word_d = in_word;
  assign aligned_d   = 10'({in_word, prev_word_q} >> offset_q);
  assign is_ctl_d    = is_ctl_token(aligned_d);

  tmds_word_decode u_decode (
    .sym  (aligned_q),
    .data (dec_data),
    .ctl  (dec_ctl)
  );

  // Stage 2: registered outputs; the field not being updated holds its last value
  always_comb begin
    out_data_d = out_data_q;
    out_c_d    = out_c_q;
    out_de_d   = out_de_q;
    if (is_ctl_q) begin
      out_de_d = 1'b0;
      out_c_d  = dec_ctl;
    end else begin
      out_de_d   = 1'b1;
      out_data_d = dec_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    tok_cnt_d  = tok_cnt_q;
    idle_cnt_d = idle_cnt_q;
    settle_d   = settle_q;
    slip       = 1'b0;
    case (state_q)
      SEARCH: begin
        if (is_ctl_q) begin
          idle_cnt_d = '0;
          if (tok_cnt_q == TOK_LAST) begin
            state_d   = LOCKED;
            tok_cnt_d = '0;
          end else begin
            tok_cnt_d = tok_cnt_q + 1'b1;
          end
        end else begin
          tok_cnt_d = '0;
          if (idle_cnt_q == SEARCH_LAST) slip = 1'b1;
          else                           idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      // Two cycles for the old-offset words to drain out of stage 1
      SETTLE: begin
        if (settle_q) begin
          state_d  = SEARCH;
          settle_d = 1'b0;
        end else begin
          settle_d = 1'b1;
        end
      end
      LOCKED: begin
        if (is_ctl_q)                       idle_cnt_d = '0;
        else if (idle_cnt_q == LOSS_LAST)   slip = 1'b1;
        else                                idle_cnt_d = idle_cnt_q + 1'b1;
      end
      default: state_d = SEARCH;
    endcase
    if (slip) begin
      state_d    = SETTLE;
      settle_d   = 1'b0;
      tok_cnt_d  = '0;
      idle_cnt_d = '0;
      offset_d   = (offset_q == OFFSET_LAST) ? '0 : offset_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      prev_word_q <= '0;
      aligned_q   <= '0;
      is_ctl_q    <= 1'b0;
      out_data_q  <= '0;
      out_c_q     <= '0;
      out_de_q    <= 1'b0;
      state_q     <= SEARCH;
      offset_q    <= '0;
      tok_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      settle_q    <= 1'b0;
    end else begin
      prev_word_q <= prev_word_d;
      aligned_q   <= aligned_d;
      is_ctl_q    <= is_ctl_d;
      out_data_q  <= out_data_d;
      out_c_q     <= out_c_d;
      out_de_q    <= out_de_d;
      state_q     <= state_d;
      offset_q    <= offset_d;
      tok_cnt_q   <= tok_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      settle_q    <= settle_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_c      = out_c_q;
  assign out_de     = out_de_q;
  assign out_locked = (state_q == LOCKED);
  assign out_offset = offset_q;

`ifdef TMDS_DECODER_LOSS_CNT_EN
  logic [15:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if ((state_q == LOCKED) && (state_d != LOCKED) && (loss_cnt_q != 16'hFFFF)) begin
      loss_cnt_d = loss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) loss_cnt_q <= '0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign out_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_decoder_align.sv
// Scoreboard bench for tmds_decoder_align: serialises encoded words at a chosen bit shift
// and checks decode, lock and offset for each word as it leaves the pipeline.
module tb_tmds_decoder_align;

  localparam int LOCK_N   = 8;
  localparam int SEARCH_T = 64;
  localparam int LOSS_T   = 64;
  localparam logic [9:0] TOK_TBL [4] = '{10'b1101010100, 10'b0010101011,
                                         10'b0101010100, 10'b1010101011};

  logic       clk_pixel = 1'b0;
  logic       rst_n     = 1'b0;
  logic [9:0] in_word   = '0;
  logic [7:0] out_data;
  logic [1:0] out_c;
  logic       out_de;
  logic       out_locked;
  logic [3:0] out_offset;
`ifdef TMDS_DECODER_LOSS_CNT_EN
  logic [15:0] out_loss_cnt;
`endif

  always #5 clk_pixel = ~clk_pixel;

  tmds_decoder_align #(
    .C_lock_tokens    (LOCK_N),
    .C_search_timeout (SEARCH_T),
    .C_loss_timeout   (LOSS_T)
  ) dut (
    .clk_pixel  (clk_pixel),
    .rst_n      (rst_n),
    .in_word    (in_word),
    .out_data   (out_data),
    .out_c      (out_c),
    .out_de     (out_de),
    .out_locked (out_locked),
`ifdef TMDS_DECODER_LOSS_CNT_EN
    .out_loss_cnt (out_loss_cnt),
`endif
    .out_offset (out_offset)
  );

  typedef struct {
    int         id;
    bit         chk_dec;
    bit         de;
    logic [7:0] data;
    logic [1:0] c;
    bit         chk_lk;
    bit         lk;
    logic [3:0] off;
    int         loss;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         shift  = 0;
  int         wid    = 0;
  int         disp   = 0;
  int         loss_exp = 0;
  logic [9:0] wprev  = '0;
  logic [1:0] last_c = 2'b00;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference DVI encoder with running disparity
  task automatic tmds_enc(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm    = '0;
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -(qm[8] ? 0 : 2) + n1q - n0q;
    end
  endtask

  // Expected offset / lock for a pure token stream starting at word 0 with the current shift
  function automatic int exp_off(input int k);
    int e, o;
    e = k + 2;
    if (shift == 0 || e < SEARCH_T - 1) return 0;
    o = 1 + (e - (SEARCH_T - 1)) / (SEARCH_T + 2);
    return (o > shift) ? shift : o;
  endfunction

  function automatic bit exp_lk(input int k);
    if (shift == 0) return (k >= LOCK_N - 1);
    return (k + 2 >= (SEARCH_T - 1) + (SEARCH_T + 2) * (shift - 1) + 2 + LOCK_N);
  endfunction

  task automatic compare(input exp_t x);
    if (x.chk_dec) begin
      check_eq($sformatf("out_de w%0d", x.id), 16'(out_de), 16'(x.de));
      check_eq($sformatf("out_c w%0d", x.id), 16'(out_c), 16'(x.c));
      if (x.de) check_eq($sformatf("out_data w%0d", x.id), 16'(out_data), 16'(x.data));
    end
    if (x.chk_lk) begin
      check_eq($sformatf("out_locked w%0d", x.id), 16'(out_locked), 16'(x.lk));
      check_eq($sformatf("out_offset w%0d", x.id), 16'(out_offset), 16'(x.off));
`ifdef TMDS_DECODER_LOSS_CNT_EN
      check_eq($sformatf("out_loss_cnt w%0d", x.id), out_loss_cnt, 16'(x.loss));
`endif
    end
  endtask

  task automatic send(input logic [9:0] w, input exp_t e);
    logic [19:0] pair;
    pair    = {w, wprev};
    in_word = 10'(pair >> (10 - shift));
    wprev   = w;
    e.id    = wid;
    wid++;
    sb.push_back(e);
    @(negedge clk_pixel);
    if (sb.size() == 3) compare(sb.pop_front());
  endtask

  task automatic tok(input logic [1:0] c, input bit cd, input bit cl, input bit lk, input logic [3:0] off);
    exp_t e;
    disp      = 0;
    last_c    = c;
    e.id      = 0;
    e.chk_dec = cd;
    e.de      = 1'b0;
    e.data    = 8'h00;
    e.c       = c;
    e.chk_lk  = cl;
    e.lk      = lk;
    e.off     = off;
    e.loss    = loss_exp;
    send(TOK_TBL[c], e);
  endtask

  task automatic dat(input logic [7:0] d, input bit cd, input bit cl, input bit lk, input logic [3:0] off);
    exp_t e;
    logic [9:0] q;
    tmds_enc(d, q);
    e.id      = 0;
    e.chk_dec = cd;
    e.de      = 1'b1;
    e.data    = d;
    e.c       = last_c;
    e.chk_lk  = cl;
    e.lk      = lk;
    e.off     = off;
    e.loss    = loss_exp;
    send(q, e);
  endtask

  task automatic do_reset();
    @(negedge clk_pixel);
    rst_n = 1'b0;
    #1;
    check_eq("rst out_locked", 16'(out_locked), 16'd0);
    check_eq("rst out_offset", 16'(out_offset), 16'd0);
    check_eq("rst out_de", 16'(out_de), 16'd0);
    check_eq("rst out_data", 16'(out_data), 16'd0);
    check_eq("rst out_c", 16'(out_c), 16'd0);
`ifdef TMDS_DECODER_LOSS_CNT_EN
    check_eq("rst out_loss_cnt", out_loss_cnt, 16'd0);
`endif
    @(negedge clk_pixel);
    sb.delete();
    wprev    = '0;
    wid      = 0;
    disp     = 0;
    loss_exp = 0;
    last_c   = 2'b00;
    in_word  = '0;
    rst_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    // Aligned stream: lock at the 8th token, then data and all four tokens
    do_reset();
    shift = 0;
    for (int k = 0; k < 20; k++) tok(2'b00, 1'b1, 1'b1, exp_lk(k), 4'd0);
    dat(8'hA5, 1'b1, 1'b1, 1'b1, 4'd0);
    for (int c = 0; c < 4; c++) tok(2'(c), 1'b1, 1'b1, 1'b1, 4'd0);
    dat(8'h3C, 1'b1, 1'b1, 1'b1, 4'd0);
    tok(2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    tok(2'b00, 1'b0, 1'b0, 1'b0, 4'd0);

    // Shift by 3: search steps the offset, locks at 3, then lock loss after LOSS_T data words
    do_reset();
    shift = 3;
    for (int k = 0; k < 210; k++) tok(2'b00, (k >= 200), 1'b1, exp_lk(k), 4'(exp_off(k)));
    dat(8'h00, 1'b1, 1'b1, 1'b1, 4'd3);
    dat(8'hFF, 1'b1, 1'b1, 1'b1, 4'd3);
    dat(8'h55, 1'b1, 1'b1, 1'b1, 4'd3);
    for (int k = 0; k < 3; k++) tok(2'b00, 1'b1, 1'b1, 1'b1, 4'd3);
    for (int j = 1; j <= LOSS_T; j++) begin
      if (j == LOSS_T) loss_exp = 1;
      dat(8'(j * 37), 1'b1, 1'b1, (j < LOSS_T), (j < LOSS_T) ? 4'd3 : 4'd4);
    end
    tok(2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    tok(2'b00, 1'b0, 1'b0, 1'b0, 4'd0);

    // Shift by 7: lock at offset 7, then asynchronous reset mid-lock
    do_reset();
    shift = 7;
    for (int k = 0; k < 475; k++) tok(2'b00, 1'b0, 1'b1, exp_lk(k), 4'(exp_off(k)));
    do_reset();

    // Aligned again: 7 tokens, one data word, then lock exactly at the 8th of the next run
    shift = 0;
    for (int k = 0; k < 7; k++) tok(2'b00, 1'b1, 1'b1, 1'b0, 4'd0);
    dat(8'h81, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 8; k++) tok(2'b00, 1'b1, 1'b1, (k == 7), 4'd0);
    tok(2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    tok(2'b00, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_decoder_align.md
Name: tmds_decoder_align

Overview:
- Receive-side counterpart of the TMDS encoder in vga2dvid; one instance per TMDS data lane.
- Takes unaligned 10-bit parallel words from a per-lane deserializer running in clk_pixel.
- Finds the word boundary by bit-slip search on control tokens and decodes each aligned word to 8-bit pixel data or 2-bit control.
- Outputs DE, monitors lock, and feeds a downstream dvid2vga sync/pixel reconstruction stage.

Parameters:
- C_lock_tokens, 8: consecutive control tokens at the current offset required to declare lock.
- C_search_timeout, 4096: cycles without a control token before the offset advances; must exceed one line period (1650 for 720p).
- C_loss_timeout, 4096: cycles without any control token, while locked, before lock is dropped.

Ports:
- clk_pixel  in  1  pixel clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_word  in  10  raw deserialized word; bit 0 is the earliest received.
- out_data  out  8  decoded pixel byte; valid when out_de=1.
- out_c  out  2  decoded control bits {c1,c0}; valid when out_de=0.
- out_de  out  1  1 = data period, 0 = control token decoded.
- out_locked  out  1  word alignment locked.
- out_offset  out  4  current bit-slip offset, 0..9.

Behaviour:
- Reset: one clock, clk_pixel; asynchronous active-low reset rst_n. On reset, all outputs and internal state clear to 0 and the state machine enters SEARCH.
- Window: prev_word is in_word registered. window[19:0] = {in_word, prev_word}. aligned[9:0] = window[offset+9 : offset].
- Stage 1 (registered): aligned_q <= aligned; is_ctl_q <= (aligned matches a control token).
- Control tokens:
  - c=00: 10'b1101010100
  - c=01: 10'b0010101011
  - c=10: 10'b0101010100
  - c=11: 10'b1010101011
- Stage 2 (registered outputs):
  - If is_ctl_q: out_de=0, out_c=token code, out_data held.
  - Else: out_de=1 and out_data is decoded from q=aligned_q:
    - w = q[9] ? ~q[7:0] : q[7:0]
    - d[0] = w[0]
    - d[i] = q[8] ? w[i]^w[i-1] : ~(w[i]^w[i-1]), for i = 1..7
  - out_c is held during data.
- Latency: 2 clk_pixel cycles from in_word completing an aligned word to the outputs. Decoding runs regardless of lock.
- State machine, driven by is_ctl_q:
  - SEARCH:
    - tok_cnt counts consecutive is_ctl_q=1 and clears on any non-token.
    - idle_cnt counts cycles since the last token.
    - When tok_cnt reaches C_lock_tokens: go to LOCKED, out_locked=1.
    - When idle_cnt reaches C_search_timeout-1: offset advances (9 wraps to 0), tok_cnt and idle_cnt clear.
  - SLIP settle: after any offset change, token evaluation is ignored for 2 cycles (pipeline flush) before counting resumes.
  - LOCKED:
    - The offset is frozen.
    - idle_cnt clears on each token.
    - When idle_cnt reaches C_loss_timeout-1: go to SEARCH, out_locked=0, offset advances by one, counters clear.
- Simultaneous events: reaching C_lock_tokens wins over the search timeout in the same cycle.
- Counter widths: sized by $clog2 of the parameters. Counters do not overflow.
- Reset mid-operation: immediate return to SEARCH with offset 0; no partial state survives.

Optional Feature:
- Macro: TMDS_DECODER_LOSS_CNT_EN.
- Defined:
  - Extra output port out_loss_cnt, 16 bits.
  - Counts LOCKED→SEARCH transitions and saturates at 16'hFFFF.
  - Cleared only by rst_n.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package tmds_pkg holds:
  - the four control-token constants
  - the state enum (SEARCH, SETTLE, LOCKED)
  - the offset width constant (4)
- One sub-module, tmds_word_decode: the purely combinational 10b to 8b/2b decode of stage 1/2. It is shared with future TERC4/HDMI work.

Test Plan:
- Serialize 10-bit words at bit offset 0 after reset:
  - 20 cycles of token c=00, then data 8'hA5 encoded by vga2dvid.
  - Required: out_locked=1 within 8+2 cycles of the first token, out_offset=0.
  - Required: out_data=8'hA5 with out_de=1, 2 cycles after the data word.
- Same stream shifted by 3 bits:
  - Required: out_offset steps 0,1,2,3 on each C_search_timeout expiry (bench uses C_search_timeout=64).
  - Required: lock at offset 3, then correct decode of 8'h00, 8'hFF, 8'h55.
- Cycle all four tokens:
  - Required: out_c = 2'b00, 01, 10, 11 respectively, with out_de=0.
- While locked, feed C_loss_timeout cycles of data only (bench uses 64):
  - Required: out_locked falls on cycle 64 and offset advances by 1.
  - Required: with TMDS_DECODER_LOSS_CNT_EN defined, out_loss_cnt=1.
- Assert rst_n=0 for 1 cycle mid-lock at offset 7:
  - Required: out_locked=0 and out_offset=0 immediately (asynchronously).
  - Required: relock after 8 tokens.
- Stream 7 tokens, 1 data word, then 8 tokens:
  - Required: no lock after the first 7.
  - Required: lock exactly at the 8th consecutive token of the second run.
